// File: rtl/vga_sync_receiver_if.sv
// Bundle of the sync inputs and recovered-timing outputs of the VGA sync receiver.
// Latency: none, wiring only.
// Backpressure: none; the raster is free-running and the receiver never stalls it.
//
// Modports:
//   master - raster source / timing consumer: drives Hsync, Vsync; observes the rest.
//   slave  - the receiver: samples Hsync, Vsync; drives counters, measurements, Frame_Start, Locked.
// Build option: VGA_SYNC_RX_ERRCNT_EN adds the 8-bit Lock_Loss_Count signal.
interface vga_sync_receiver_if #(
    parameter int CNT_W = 11
);
    logic             Hsync;
    logic             Vsync;
    logic [CNT_W-1:0] H_Count_Value;
    logic [CNT_W-1:0] V_Count_Value;
    logic [CNT_W-1:0] H_Total;
    logic [CNT_W-1:0] H_Sync_Width;
    logic [CNT_W-1:0] V_Total;
    logic [CNT_W-1:0] V_Sync_Width;
    logic             Frame_Start;
    logic             Locked;
`ifdef VGA_SYNC_RX_ERRCNT_EN
    logic [7:0]       Lock_Loss_Count;
`endif

    modport master (
        output Hsync, Vsync,
        input  H_Count_Value, V_Count_Value, H_Total, H_Sync_Width,
        input  V_Total, V_Sync_Width, Frame_Start, Locked
`ifdef VGA_SYNC_RX_ERRCNT_EN
        , input Lock_Loss_Count
`endif
    );

    modport slave (
        input  Hsync, Vsync,
        output H_Count_Value, V_Count_Value, H_Total, H_Sync_Width,
        output V_Total, V_Sync_Width, Frame_Start, Locked
`ifdef VGA_SYNC_RX_ERRCNT_EN
        , output Lock_Loss_Count
`endif
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// Recovers pixel/line position from active-low Hsync/Vsync, measures raster timing, declares lock.
// Latency: an input edge sampled at clock n is acted on at clock n+1 (counters reset 2 clocks after the pin edge).
// Backpressure: none; the receiver follows the external raster and cannot stall it.
//
// Ports: clk (pixel clock), rst (synchronous, active high), bus (vga_sync_receiver_if.slave):
//   Hsync/Vsync in; H/V_Count_Value, H_Total, H_Sync_Width, V_Total, V_Sync_Width, Frame_Start, Locked out.
// Build option: VGA_SYNC_RX_ERRCNT_EN adds Lock_Loss_Count (saturating count of lock drops, cleared by rst).
module vga_sync_receiver #(
    parameter int CNT_W       = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_sync_receiver_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {SEARCH, ARM, VERIFY, LOCKED} state_t;

    state_t             state_q, state_d;
    logic               hs_q, hs_p, vs_q, vs_p;
    logic [CNT_W-1:0]   h_cnt, hw_cnt, v_cnt, vw_cnt;
    logic [CNT_W-1:0]   h_total, h_sync_width, v_total, v_sync_width;
    logic               frame_start;
    logic               locked_q, locked_d;
    logic               line_err;
    logic               first_line;         // next hfall only sets the reference period
    logic [3:0]         match_q, match_d;
    logic [4*CNT_W-1:0] prev_rec;
    logic               lock_lost;

    logic               hfall, hrise, vfall, vrise;
    logic [CNT_W-1:0]   h_period;
    logic [CNT_W-1:0]   h_total_nxt, h_sync_width_nxt, v_total_nxt, v_sync_width_nxt;
    logic [4*CNT_W-1:0] cur_rec;
    logic               rec_match;
    logic               sync_timeout;
    logic [4:0]         match_inc;

    assign hfall = hs_p & ~hs_q;
    assign hrise = ~hs_p & hs_q;
    assign vfall = vs_p & ~vs_q;
    assign vrise = ~vs_p & vs_q;

    // Saturating h_cnt+1: both the free-running increment and the measured line period.
    assign h_period = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + CNT_ONE;

    // The frame record compared at vfall includes any measurement landing on that same clock.
    assign h_total_nxt      = hfall ? h_period : h_total;
    assign h_sync_width_nxt = hrise ? hw_cnt   : h_sync_width;
    assign v_total_nxt      = vfall ? v_cnt    : v_total;
    assign v_sync_width_nxt = vrise ? vw_cnt   : v_sync_width;
    assign cur_rec   = {h_total_nxt, h_sync_width_nxt, v_total_nxt, v_sync_width_nxt};
    assign rec_match = (cur_rec == prev_rec);

    // Fires once, on the clock h_cnt enters saturation, so a raster resuming while h_cnt is
    // still pinned at max is not knocked back to SEARCH again.
    assign sync_timeout = !hfall && (h_cnt == CNT_MAX - CNT_ONE);

    assign match_inc = {1'b0, match_q} + 5'd1;

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        locked_d  = locked_q;
        lock_lost = 1'b0;
        if (sync_timeout) begin
            state_d   = SEARCH;
            match_d   = '0;
            locked_d  = 1'b0;
            lock_lost = (state_q == LOCKED);
        end else if (vfall) begin
            case (state_q)
                SEARCH: state_d = ARM;
                ARM: begin
                    match_d = '0;
                    state_d = VERIFY;
                end
                VERIFY: begin
                    if (rec_match && !line_err) begin
                        match_d = match_inc[3:0];
                        if (match_inc >= 5'(LOCK_FRAMES)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (!rec_match || line_err) begin
                        state_d   = VERIFY;
                        match_d   = '0;
                        locked_d  = 1'b0;
                        lock_lost = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q         <= 1'b1;
            hs_p         <= 1'b1;
            vs_q         <= 1'b1;
            vs_p         <= 1'b1;
            h_cnt        <= '0;
            hw_cnt       <= '0;
            v_cnt        <= '0;
            vw_cnt       <= '0;
            h_total      <= '0;
            h_sync_width <= '0;
            v_total      <= '0;
            v_sync_width <= '0;
            frame_start  <= 1'b0;
            line_err     <= 1'b0;
            first_line   <= 1'b1;
            prev_rec     <= '0;
            state_q      <= SEARCH;
            match_q      <= '0;
            locked_q     <= 1'b0;
        end else begin
            hs_q <= bus.Hsync;
            hs_p <= hs_q;
            vs_q <= bus.Vsync;
            vs_p <= vs_q;

            if (hfall) begin
                h_total <= h_period;
                h_cnt   <= '0;
            end else begin
                h_cnt   <= h_period;
            end

            if (hrise) begin
                h_sync_width <= hw_cnt;
                hw_cnt       <= '0;
            end else if (!hs_q && hw_cnt != CNT_MAX) begin
                hw_cnt <= hw_cnt + CNT_ONE;
            end

            // A line whose hfall coincides with vfall belongs to the new frame and is not counted.
            if (vfall) begin
                v_total <= v_cnt;
                v_cnt   <= '0;
            end else if (hfall && v_cnt != CNT_MAX) begin
                v_cnt <= v_cnt + CNT_ONE;
            end

            if (vrise) begin
                v_sync_width <= vw_cnt;
                vw_cnt       <= '0;
            end else if (hfall && !vs_q && vw_cnt != CNT_MAX) begin
                vw_cnt <= vw_cnt + CNT_ONE;
            end

            frame_start <= vfall;

            // line_err is consumed by the lock FSM on this vfall, then restarts for the new frame.
            // The first line of a frame has no trusted reference period, so it is not checked.
            if (vfall) begin
                line_err   <= 1'b0;
                first_line <= !hfall;
                prev_rec   <= cur_rec;
            end else if (hfall) begin
                if (!first_line && h_period != h_total)
                    line_err <= 1'b1;
                first_line <= 1'b0;
            end

            state_q  <= state_d;
            match_q  <= match_d;
            locked_q <= locked_d;
        end
    end

`ifdef VGA_SYNC_RX_ERRCNT_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            loss_cnt <= '0;
        else if (lock_lost && loss_cnt != 8'hFF)
            loss_cnt <= loss_cnt + 8'd1;
    end

    assign bus.Lock_Loss_Count = loss_cnt;
`endif

    assign bus.H_Count_Value = h_cnt;
    assign bus.V_Count_Value = v_cnt;
    assign bus.H_Total       = h_total;
    assign bus.H_Sync_Width  = h_sync_width;
    assign bus.V_Total       = v_total;
    assign bus.V_Sync_Width  = v_sync_width;
    assign bus.Frame_Start   = frame_start;
    assign bus.Locked        = locked_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: drives synthetic rasters, scoreboards the per-frame report.
// Latency: expected frame records are queued at each driven Vsync fall and popped on Frame_Start.
// Backpressure: none; the bench drives one raster pixel per clock.
module tb_vga_sync_receiver;

    localparam int CNT_W = 11;
    localparam int HS0   = 4;   // Hsync falls this many clocks into every line

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vga_sync_receiver_if #(.CNT_W(CNT_W)) bus ();

    vga_sync_receiver #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int ht;
        int hsw;
        int vt;
        int vsw;
        bit lk;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_err  = 0;
    int n_push = 0;
    int fs_seen = 0;
    bit fs_prev = 1'b0;

    // Timing of the previous full frame, i.e. what the next Frame_Start must report.
    int prev_ht = 0, prev_hsw = 0, prev_vt = 0, prev_vsw = 0;

    // Raster position of the pixel currently on the inputs, for per-cycle counter checks.
    int cur_line = 0, cur_h = 0, cur_per = 1, cur_lines = 0;
    bit cnt_chk_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic hs, input logic vs);
        @(posedge clk);
        #1;
        bus.Hsync = hs;
        bus.Vsync = vs;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_hcnt"}, bus.H_Count_Value, 0);
        check_val({tag, "_vcnt"}, bus.V_Count_Value, 0);
        check_val({tag, "_htot"}, bus.H_Total, 0);
        check_val({tag, "_hsw"},  bus.H_Sync_Width, 0);
        check_val({tag, "_vtot"}, bus.V_Total, 0);
        check_val({tag, "_vsw"},  bus.V_Sync_Width, 0);
        check_val({tag, "_fs"},   bus.Frame_Start, 0);
        check_val({tag, "_lock"}, bus.Locked, 0);
`ifdef VGA_SYNC_RX_ERRCNT_EN
        check_val({tag, "_loss"}, bus.Lock_Loss_Count, 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.Hsync = 1'b1;
        bus.Vsync = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero(tag);
        prev_ht = 0; prev_hsw = 0; prev_vt = 0; prev_vsw = 0;
    endtask

    // One frame: Vsync falls at line 0 pixel 0, Hsync low for hsw clocks from pixel HS0.
    // stretch >= 0 adds one extra clock at the end of that line; n_lines < lines truncates.
    task automatic drive_frame(input int per, input int hsw, input int lines, input int vsw,
                               input int stretch, input int n_lines, input bit exp_lock,
                               input bit cnt_chk);
        exp_t e;
        int len;
        e.ht = prev_ht; e.hsw = prev_hsw; e.vt = prev_vt; e.vsw = prev_vsw; e.lk = exp_lock;
        sb.push_back(e);
        n_push++;
        cur_per = per;
        cur_lines = lines;
        cnt_chk_en = cnt_chk;
        for (int l = 0; l < n_lines; l++) begin
            len = per + ((l == stretch) ? 1 : 0);
            for (int h = 0; h < len; h++) begin
                tick(!(h >= HS0 && h < HS0 + hsw), !(l < vsw));
                cur_line = l;
                cur_h = h;
            end
        end
        cnt_chk_en = 1'b0;
        prev_ht = per; prev_hsw = hsw; prev_vt = lines; prev_vsw = vsw;
    endtask

    // Scoreboard and per-cycle position checks, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int t, exp_h, exp_v;
        if (bus.Frame_Start) begin
            fs_seen++;
            check_val("fs_width", fs_prev, 0);
            check_val("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("h_total", bus.H_Total, e.ht);
                check_val("h_sync_width", bus.H_Sync_Width, e.hsw);
                check_val("v_total", bus.V_Total, e.vt);
                check_val("v_sync_width", bus.V_Sync_Width, e.vsw);
                check_val("locked", bus.Locked, e.lk);
            end
        end
        fs_prev = bus.Frame_Start;
        if (cnt_chk_en) begin
            exp_h = (cur_h - HS0 - 2 + cur_per) % cur_per;
            t = cur_line * cur_per + cur_h;
            if (t < 2)
                exp_v = cur_lines;
            else
                exp_v = cur_line + ((cur_h >= HS0 + 2) ? 1 : 0);
            check_val("h_count", bus.H_Count_Value, exp_h);
            check_val("v_count", bus.V_Count_Value, exp_v);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        bus.Hsync = 1'b1;
        bus.Vsync = 1'b1;
        repeat (3) @(posedge clk);
        do_reset("rst0");

        // 800-clock lines, Hsync low 96, Vsync low 2 lines; lock on the 4th vfall.
        for (int i = 0; i < 5; i++)
            drive_frame(800, 96, 8, 2, -1, 8, i >= 3, 1'b0);

        // 525-line frames: the changed record drops lock, then V_Total=525 is reported.
        drive_frame(16, 3, 525, 2, -1, 525, 1'b1, 1'b0);
        drive_frame(16, 3, 525, 2, -1, 525, 1'b0, 1'b0);
        drive_frame(16, 3, 525, 2, -1, 1, 1'b0, 1'b0);
        do_reset("rst1");

        // Short raster; frame 3 is checked pixel by pixel.
        for (int i = 0; i < 5; i++)
            drive_frame(20, 3, 10, 1, -1, 10, i >= 3, i == 2);

        // One 21-clock line drops lock at the next vfall; two clean frames relock.
        drive_frame(20, 3, 10, 1, 3, 10, 1'b1, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 10, 1'b0, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 10, 1'b0, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 10, 1'b1, 1'b0);

        // Sync lost: Hsync held high past saturation.
        repeat (2100) tick(1'b1, 1'b1);
        @(negedge clk);
        check_val("to_hcnt", bus.H_Count_Value, 2047);
        check_val("to_lock", bus.Locked, 0);
        check_val("to_htot_hold", bus.H_Total, 20);
        check_val("to_vcnt_hold", bus.V_Count_Value, 10);
        // Back from SEARCH: lock again on the 4th vfall.
        for (int i = 0; i < 4; i++)
            drive_frame(20, 3, 10, 1, -1, 10, i >= 3, 1'b0);

        drive_frame(20, 3, 10, 1, 6, 10, 1'b1, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 10, 1'b0, 1'b0);
`ifdef VGA_SYNC_RX_ERRCNT_EN
        @(negedge clk);
        check_val("loss_cnt", bus.Lock_Loss_Count, 3);
`endif
        drive_frame(20, 3, 10, 1, -1, 10, 1'b0, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 10, 1'b1, 1'b0);

        // Reset mid-frame while locked, then relock on the 4th vfall.
        drive_frame(20, 3, 10, 1, -1, 5, 1'b1, 1'b0);
        do_reset("rst2");
        drive_frame(20, 3, 10, 1, -1, 10, 1'b0, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 10, 1'b0, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 10, 1'b0, 1'b0);
        drive_frame(20, 3, 10, 1, -1, 1, 1'b1, 1'b0);

        repeat (5) tick(1'b1, 1'b1);
        @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        check_val("fs_count", fs_seen, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
